// File: rtl/regfile_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// regfile_wr_arbiter_pkg : shared types and helpers for the regfile write arbiter
// Revision 1.0
// ============================================================================
package regfile_wr_arbiter_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int ADDR_W_DEF = 5;
    localparam int DEPTH_DEF  = 32;

    // Width needed to hold 0..val-1; never returns less than 1.
    function automatic int clog2(input int val);
        int res;
        int rem;
        res = 0;
        rem = val - 1;
        while (rem > 0) begin
            res++;
            rem = rem >> 1;
        end
        return (res == 0) ? 1 : res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_wr_arbiter_rr_arbiter : combinational round-robin grant from ptr
// Revision 1.0
// ============================================================================
module regfile_wr_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_wr_arbiter : clears the regfile after reset, then round-robin shares
//                      its single write port between NUM_REQ writeback sources
// Revision 1.0
// ============================================================================
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int BIT_SIZE     = 32,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int NUM_REQ      = 3,
    parameter bit ZERO_PROTECT = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*BIT_SIZE-1:0]  req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         RegWrite,
    output logic [ADDR_W-1:0]            Write_addr,
    output logic [BIT_SIZE-1:0]          Write_data,
    output logic                         init_busy
);

    localparam int PTR_W = clog2(NUM_REQ);
    localparam int CNT_W = clog2(DEPTH);

    state_t              state, state_next;
    logic [CNT_W-1:0]    clr_cnt, clr_cnt_next;
    logic [PTR_W-1:0]    rr_ptr, rr_ptr_next;
    logic [NUM_REQ-1:0]  grant;
    logic [PTR_W-1:0]    grant_idx;
    logic [ADDR_W-1:0]   sel_addr, addr_next;
    logic [BIT_SIZE-1:0] sel_data, data_next;
    logic                wr_next, busy_next, transfer;

    regfile_wr_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Requests are held off (not dropped) until the clear sequence finishes.
    assign req_ready = (state == RUN) ? grant : '0;
    assign transfer  = |req_ready;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*BIT_SIZE +: BIT_SIZE];
            end
        end
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        rr_ptr_next  = rr_ptr;
        wr_next      = 1'b0;
        addr_next    = Write_addr;
        data_next    = Write_data;
        busy_next    = init_busy;
        case (state)
            CLEAR: begin
                wr_next   = 1'b1;
                addr_next = ADDR_W'(clr_cnt);
                data_next = '0;
                if (clr_cnt == CNT_W'(DEPTH - 1)) begin
                    state_next   = RUN;
                    busy_next    = 1'b0;
                    clr_cnt_next = '0;
                end else begin
                    clr_cnt_next = clr_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                busy_next = 1'b0;
                if (transfer) begin
                    // Writes to address 0 still complete the handshake.
                    wr_next     = !(ZERO_PROTECT && (sel_addr == '0));
                    addr_next   = sel_addr;
                    data_next   = sel_data;
                    rr_ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                                      : grant_idx + PTR_W'(1);
                end
            end
            default: begin
                state_next   = CLEAR;
                clr_cnt_next = '0;
                rr_ptr_next  = '0;
                busy_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            rr_ptr     <= '0;
            RegWrite   <= 1'b0;
            Write_addr <= '0;
            Write_data <= '0;
            init_busy  <= 1'b1;
        end else begin
            state      <= state_next;
            clr_cnt    <= clr_cnt_next;
            rr_ptr     <= rr_ptr_next;
            RegWrite   <= wr_next;
            Write_addr <= addr_next;
            Write_data <= data_next;
            init_busy  <= busy_next;
        end
    end

endmodule
`default_nettype wire
